// File: rtl/mem_bus_arbiter_pkg.sv
// mem_bus_arbiter_pkg: slot owner and FSM encodings plus RAM bus widths
package mem_bus_arbiter_pkg;
    localparam int ADDR_W = 16;
    localparam int DATA_W = 8;
    typedef enum logic {OWNER_CPU = 1'b0, OWNER_DMA = 1'b1} owner_e;
    typedef enum logic {S_CPU = 1'b0, S_DMA = 1'b1} state_e;
endpackage

// File: rtl/mem_bus_arbiter_if.sv
// mem_bus_arbiter_if: 6502, DMA and RAM side signals around the arbiter
interface mem_bus_arbiter_if;
    import mem_bus_arbiter_pkg::*;
    logic [ADDR_W-1:0] cpu_ab;
    logic [DATA_W-1:0] cpu_do;
    logic              cpu_we;
    logic [DATA_W-1:0] cpu_di;
    logic              cpu_rdy;
    logic              dma_req;
    logic [ADDR_W-1:0] dma_addr;
    logic              dma_we;
    logic [DATA_W-1:0] dma_wdata;
    logic              dma_gnt;
    logic              dma_rvalid;
    logic [DATA_W-1:0] dma_rdata;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_we;
    logic [DATA_W-1:0] mem_rdata;
    modport slave (
        input  cpu_ab, cpu_do, cpu_we, dma_req, dma_addr, dma_we, dma_wdata, mem_rdata,
        output cpu_di, cpu_rdy, dma_gnt, dma_rvalid, dma_rdata, mem_addr, mem_wdata, mem_we
    );
    modport master (
        output cpu_ab, cpu_do, cpu_we, dma_req, dma_addr, dma_we, dma_wdata, mem_rdata,
        input  cpu_di, cpu_rdy, dma_gnt, dma_rvalid, dma_rdata, mem_addr, mem_wdata, mem_we
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: cycle-stealing share of one RAM port between the 6502 and a DMA requester
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int DMA_MAX_RUN = 4,
    parameter int CPU_MIN_RUN = 1
) (
    input  logic               clk,
    input  logic               reset,
    mem_bus_arbiter_if.slave   bus
);
    localparam logic [3:0] MAX_RUN = 4'(DMA_MAX_RUN);
    localparam logic [3:0] MIN_RUN = 4'(CPU_MIN_RUN);
    state_e            r_state;
    owner_e            r_prev_owner;
    logic [3:0]        r_dma_run;
    logic [3:0]        r_cpu_run;
    logic [DATA_W-1:0] r_hold_di;
    logic              r_dma_rvalid;
    logic              w_dma_win;
    assign w_dma_win = !reset && bus.dma_req &&
                       (r_state == S_CPU ? r_cpu_run >= MIN_RUN : r_dma_run < MAX_RUN);
    assign bus.dma_gnt    = w_dma_win;
    assign bus.cpu_rdy    = !w_dma_win;
    assign bus.mem_addr   = w_dma_win ? bus.dma_addr  : bus.cpu_ab;
    assign bus.mem_wdata  = w_dma_win ? bus.dma_wdata : bus.cpu_do;
    assign bus.mem_we     = w_dma_win ? bus.dma_we    : bus.cpu_we;
    // a stalled 6502 keeps seeing the byte from its last CPU-owned read
    assign bus.cpu_di     = r_prev_owner == OWNER_CPU ? bus.mem_rdata : r_hold_di;
    assign bus.dma_rdata  = bus.mem_rdata;
    assign bus.dma_rvalid = r_dma_rvalid;
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_CPU;
            r_cpu_run    <= MIN_RUN;
            r_dma_run    <= 4'd0;
            r_prev_owner <= OWNER_CPU;
            r_hold_di    <= '0;
            r_dma_rvalid <= 1'b0;
        end else begin
            r_prev_owner <= w_dma_win ? OWNER_DMA : OWNER_CPU;
            r_dma_rvalid <= w_dma_win && !bus.dma_we;
            if (r_prev_owner == OWNER_CPU)
                r_hold_di <= bus.mem_rdata;
            case (r_state)
                S_CPU: begin
                    if (w_dma_win) begin
                        r_state   <= S_DMA;
                        r_dma_run <= 4'd1;
                    end else if (r_cpu_run != 4'hf) begin
                        r_cpu_run <= r_cpu_run + 4'd1;
                    end
                end
                S_DMA: begin
                    if (w_dma_win) begin
                        r_dma_run <= r_dma_run + 4'd1;
                    end else begin
                        r_state   <= S_CPU;
                        r_cpu_run <= 4'd1;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: random cpu/dma traffic against a slot-history reference model
module tb_mem_bus_arbiter;
    localparam int MAXR = 4;
    localparam int MINR = 1;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;
    mem_bus_arbiter_if bus();
    mem_bus_arbiter #(.DMA_MAX_RUN(MAXR), .CPU_MIN_RUN(MINR)) dut (
        .clk(clk), .reset(reset), .bus(bus.slave)
    );
    logic [7:0] ram [256];
    logic [7:0] ref_mem [256];
    always @(posedge clk) begin
        if (bus.mem_we) ram[bus.mem_addr[7:0]] <= bus.mem_wdata;
        bus.mem_rdata <= ram[bus.mem_addr[7:0]];
    end
    int n_checks = 0;
    int n_fails = 0;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask
    bit         hist[$];
    bit         any_dma = 1'b0;
    bit         known = 1'b0;
    bit         exp_rv = 1'b0;
    logic [7:0] exp_rdata = '0;
    logic [7:0] last_cpu = '0;
    bit         cpu_new = 1'b1;
    bit         dma_new = 1'b1;
    // DMA may win after MINR CPU slots (reset counts as MINR) and for at most MAXR slots in a row
    function automatic bit dma_wins(input bit req);
        int d = 0;
        int c = 0;
        if (!req) return 1'b0;
        if (hist.size() > 0 && hist[hist.size()-1]) begin
            for (int i = hist.size() - 1; i >= 0 && hist[i]; i--) d++;
            return d < MAXR;
        end
        for (int i = hist.size() - 1; i >= 0 && !hist[i]; i--) c++;
        if (!any_dma) c += MINR;
        return c >= MINR;
    endfunction
    task automatic step(input bit rst_v, input int req_pct, output bit gnt_obs);
        bit         e_dma;
        bit         e_we;
        logic [15:0] e_addr;
        logic [7:0] e_wd;
        logic [7:0] data;
        @(negedge clk);
        reset = rst_v;
        if (cpu_new) begin
            bus.cpu_ab = 16'($urandom_range(0, 255));
            bus.cpu_do = 8'($urandom);
            bus.cpu_we = ($urandom_range(0, 3) == 0);
        end
        if (dma_new) begin
            bus.dma_req   = ($urandom_range(0, 99) < req_pct);
            bus.dma_addr  = 16'($urandom_range(0, 255));
            bus.dma_we    = 1'($urandom);
            bus.dma_wdata = 8'($urandom);
        end
        e_dma  = !rst_v && dma_wins(bus.dma_req);
        e_addr = e_dma ? bus.dma_addr : bus.cpu_ab;
        e_we   = e_dma ? bus.dma_we : bus.cpu_we;
        e_wd   = e_dma ? bus.dma_wdata : bus.cpu_do;
        #1;
        check("dma_gnt", 32'(bus.dma_gnt), 32'(e_dma));
        check("cpu_rdy", 32'(bus.cpu_rdy), 32'(!e_dma));
        check("mem_addr", 32'(bus.mem_addr), 32'(e_addr));
        check("mem_we", 32'(bus.mem_we), 32'(e_we));
        if (e_we) check("mem_wdata", 32'(bus.mem_wdata), 32'(e_wd));
        if (known && !rst_v) begin
            check("cpu_di", 32'(bus.cpu_di), 32'(last_cpu));
            check("dma_rvalid", 32'(bus.dma_rvalid), 32'(exp_rv));
            if (exp_rv) check("dma_rdata", 32'(bus.dma_rdata), 32'(exp_rdata));
        end
        gnt_obs = bus.dma_gnt;
        data = ref_mem[e_addr[7:0]];
        if (e_we) ref_mem[e_addr[7:0]] = e_wd;
        if (rst_v) begin
            hist.delete();
            any_dma = 1'b0;
            known   = 1'b1;
            exp_rv  = 1'b0;
        end else begin
            hist.push_back(e_dma);
            if (hist.size() > 32) void'(hist.pop_front());
            any_dma |= e_dma;
            exp_rv    = e_dma && !bus.dma_we;
            exp_rdata = data;
        end
        if (!e_dma) last_cpu = data;
        cpu_new = !e_dma;
        dma_new = e_dma || !bus.dma_req;
    endtask
    initial begin
        bit g;
        for (int a = 0; a < 256; a++) begin
            ram[a]     = 8'($urandom);
            ref_mem[a] = ram[a];
        end
        bus.dma_req = 1'b0;
        repeat (2) step(1'b1, 0, g);
        repeat (200) step(1'b0, 5, g);
        step(1'b1, 100, g);
        check("reset_no_gnt", 32'(g), 32'd0);
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 100, g);
            check("ddddc", 32'(g), 32'((i % 5) != 4));
        end
        repeat (2) step(1'b0, 100, g);
        step(1'b1, 100, g);
        check("rst_mid_run", 32'(g), 32'd0);
        step(1'b0, 100, g);
        check("post_rst_gnt", 32'(g), 32'd1);
        repeat (4000) step($urandom_range(0, 299) == 0, 50, g);
        repeat (300) step(1'b0, 90, g);
        @(negedge clk);
        for (int a = 0; a < 256; a++) check("ram_image", 32'(ram[a]), 32'(ref_mem[a]));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
